// File: rtl/rca64_sequencer_if.sv
// Bundle of the request, response and 32-bit adder signals of rca64_sequencer.
// slave is the sequencer's view; master is the surrounding datapath/adder view.
interface rca64_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_cin;
    logic        req_sub;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        add_flag;
    logic [31:0] add_sum;
    logic        add_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_sub,
        input  rsp_ready,
        input  add_sum, add_cout,
        output req_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_ovf,
        output add_a, add_b, add_cin, add_flag
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_sub,
        output rsp_ready,
        output add_sum, add_cout,
        input  req_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_ovf,
        input  add_a, add_b, add_cin, add_flag
    );
endinterface

// File: rtl/rca64_sequencer.sv
// Runs a 64-bit add/subtract as two passes (low word, then high word) through an
// external registered 32-bit ripple-carry adder with LAT register stages.
module rca64_sequencer #(
    parameter int LAT = 2
) (
    input logic               CLK,
    input logic               RST_N,
    rca64_sequencer_if.slave  bus
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_sum_q,   rsp_sum_d;
    logic             rsp_cout_q,  rsp_cout_d;
    logic             rsp_ovf_q,   rsp_ovf_d;
    logic [31:0]      add_a_q,     add_a_d;
    logic [31:0]      add_b_q,     add_b_d;
    logic             add_cin_q,   add_cin_d;
    logic             add_flag_q,  add_flag_d;
    logic [31:0]      a_hi_q,      a_hi_d;
    logic [31:0]      b_hi_q,      b_hi_d;
    logic             sub_q,       sub_d;
    logic [31:0]      sum_lo_q,    sum_lo_d;

    // Signed overflow of the top word: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input logic signed [31:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        add_flag_d  = add_flag_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        sub_d       = sub_q;
        sum_lo_d    = sum_lo_q;

        case (state_q)
            IDLE: begin
                // req_ready comes up one edge after reset release.
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (bus.req_valid) begin
                    a_hi_d      = bus.req_a[63:32];
                    b_hi_d      = bus.req_b[63:32];
                    sub_d       = bus.req_sub;
                    add_a_d     = bus.req_a[31:0];
                    add_b_d     = bus.req_b[31:0];
                    add_cin_d   = bus.req_cin;
                    add_flag_d  = bus.req_sub;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = LO;
                end
            end

            LO: begin
                if (cnt_q == LAT_C) begin
                    // Low-word carry is carried forward in add_cin for the high pass.
                    sum_lo_d  = bus.add_sum;
                    add_a_d   = a_hi_q;
                    add_b_d   = b_hi_q;
                    add_cin_d = bus.add_cout;
                    cnt_d     = '0;
                    state_d   = HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HI: begin
                if (cnt_q == LAT_C) begin
                    rsp_sum_d   = {bus.add_sum, sum_lo_q};
                    rsp_cout_d  = bus.add_cout;
                    rsp_ovf_d   = add_ovf($signed(a_hi_q),
                                          $signed(sub_q ? ~b_hi_q : b_hi_q),
                                          $signed(bus.add_sum));
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            add_flag_q  <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            sub_q       <= 1'b0;
            sum_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            add_flag_q  <= add_flag_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            sub_q       <= sub_d;
            sum_lo_q    <= sum_lo_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.add_flag  = add_flag_q;

endmodule

// File: tb/tb_rca64_sequencer.sv
// Bench for rca64_sequencer: a LAT-stage 32-bit adder model plus directed and
// random 64-bit requests checked against a plain 65-bit arithmetic reference.
module tb_rca64_sequencer;

    localparam int LAT = 2;
    localparam int RSP_LAT = 2 * (LAT + 1);

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    rca64_sequencer_if sif();

    rca64_sequencer #(.LAT(LAT)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (sif)
    );

    // 32-bit adder with LAT register stages; FLAG inverts B inside the adder.
    bit [32:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= {1'b0, sif.add_a} + {1'b0, (sif.add_flag ? ~sif.add_b : sif.add_b)}
                   + {32'd0, sif.add_cin};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sif.add_sum  = pipe[LAT-1][31:0];
    assign sif.add_cout = pipe[LAT-1][32];

    // Reference: {ovf, cout, sum} of the full 64-bit operation.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] beff;
        logic [64:0] t;
        logic        ovf;
        beff = sub ? ~b : b;
        t    = {1'b0, a} + {1'b0, beff} + {64'd0, cin};
        ovf  = (a[63] == beff[63]) && (t[63] != a[63]);
        return {ovf, t[64], t[63:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(sif.req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(sif.rsp_valid), 64'd0);
        check({tag, "_rsp_sum"},   sif.rsp_sum, 64'd0);
        check({tag, "_rsp_flags"}, {62'd0, sif.rsp_cout, sif.rsp_ovf}, 64'd0);
        check({tag, "_add_ab"},    {sif.add_a, sif.add_b}, 64'd0);
        check({tag, "_add_ctl"},   {62'd0, sif.add_cin, sif.add_flag}, 64'd0);
    endtask

    // Waits for req_ready, presents the request for one edge, checks the low-word load.
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
        int n = 0;
        while (!sif.req_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_wait", 64'(n < 100), 64'd1);
        sif.req_valid = 1'b1;
        sif.req_a     = a;
        sif.req_b     = b;
        sif.req_cin   = cin;
        sif.req_sub   = sub;
        tick();
        sif.req_valid = 1'b0;
        sif.req_a     = {$urandom, $urandom};
        sif.req_b     = {$urandom, $urandom};
        sif.req_cin   = 1'($urandom);
        sif.req_sub   = 1'($urandom);
        check("accept_ready_low", 64'(sif.req_ready), 64'd0);
        check("load_lo_ab", {sif.add_a, sif.add_b}, {a[31:0], b[31:0]});
        check("load_lo_ctl", {62'd0, sif.add_cin, sif.add_flag}, {62'd0, cin, sub});
    endtask

    // Called right after the accept edge: waits for rsp_valid and checks the result.
    task automatic wait_rsp(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub);
        logic [65:0] exp;
        int n = 0;
        exp = model(a, b, cin, sub);
        do begin
            tick();
            n++;
        end while (!sif.rsp_valid && n < 100);
        check({tag, "_latency"}, 64'(n), 64'(RSP_LAT));
        check({tag, "_sum"},     sif.rsp_sum, exp[63:0]);
        check({tag, "_cout"},    64'(sif.rsp_cout), 64'(exp[64]));
        check({tag, "_ovf"},     64'(sif.rsp_ovf), 64'(exp[65]));
    endtask

    task automatic drain(input string tag, input logic [63:0] exp_sum);
        int d = int'($urandom_range(0, 2));
        for (int i = 0; i < d; i++) begin
            tick();
            check({tag, "_hold"}, sif.rsp_sum, exp_sum);
        end
        sif.rsp_ready = 1'b1;
        tick();
        sif.rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, {62'd0, sif.rsp_valid, sif.req_ready}, 64'd1);
    endtask

    task automatic txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub);
        logic [65:0] exp;
        exp = model(a, b, cin, sub);
        send(a, b, cin, sub);
        wait_rsp(tag, a, b, cin, sub);
        drain(tag, exp[63:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb, na, nb;
        logic        rc, rs;
        logic [65:0] exp;

        sif.req_valid = 1'b0;
        sif.req_a     = '0;
        sif.req_b     = '0;
        sif.req_cin   = 1'b0;
        sif.req_sub   = 1'b0;
        sif.rsp_ready = 1'b0;

        #2;
        check_all_zero("reset");
        tick();
        tick();
        #2;
        RST_N = 1'b1;
        #1;
        check("ready_before_edge", 64'(sif.req_ready), 64'd0);
        tick();
        check("ready_after_reset", 64'(sif.req_ready), 64'd1);

        txn("basic",  64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0, 1'b0);
        txn("carry",  64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        txn("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1);
        txn("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1);
        txn("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        txn("wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        txn("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);

        // Backpressure: response held while new requests are presented.
        ra = 64'h1234_5678_9ABC_DEF0;
        rb = 64'h0FED_CBA9_8765_4321;
        exp = model(ra, rb, 1'b0, 1'b1);
        send(ra, rb, 1'b0, 1'b1);
        wait_rsp("bp", ra, rb, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            sif.req_valid = 1'b1;
            sif.req_a     = {$urandom, $urandom};
            sif.req_b     = {$urandom, $urandom};
            tick();
            check("bp_valid", {62'd0, sif.rsp_valid, sif.req_ready}, 64'd2);
            check("bp_sum", sif.rsp_sum, exp[63:0]);
            check("bp_flags", {62'd0, sif.rsp_cout, sif.rsp_ovf}, {62'd0, exp[64], exp[65]});
            check("bp_add", {sif.add_a, sif.add_b}, {ra[63:32], rb[63:32]});
        end
        na = {$urandom, $urandom};
        nb = {$urandom, $urandom};
        sif.req_a     = na;
        sif.req_b     = nb;
        sif.req_cin   = 1'b1;
        sif.req_sub   = 1'b0;
        sif.rsp_ready = 1'b1;
        tick();
        sif.rsp_ready = 1'b0;
        check("bp_release", {62'd0, sif.rsp_valid, sif.req_ready}, 64'd1);
        check("bp_no_same_cycle", {sif.add_a, sif.add_b}, {ra[63:32], rb[63:32]});
        tick();
        sif.req_valid = 1'b0;
        check("bp_next_accept", 64'(sif.req_ready), 64'd0);
        check("bp_next_lo", {sif.add_a, sif.add_b}, {na[31:0], nb[31:0]});
        wait_rsp("bp_next", na, nb, 1'b1, 1'b0);
        exp = model(na, nb, 1'b1, 1'b0);
        drain("bp_next", exp[63:0]);

        // Asynchronous reset while the high word is in flight.
        send(64'hDEAD_BEEF_0000_0001, 64'h0123_4567_FFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < LAT + 2; i++) tick();
        #2;
        RST_N = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        tick();
        #2;
        RST_N = 1'b1;
        tick();
        check("ready_after_mid_reset", 64'(sif.req_ready), 64'd1);
        txn("post_reset", 64'h0000_0002_8000_0000, 64'h0000_0003_8000_0000, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case (i % 4)
                1: ra[31:0] = 32'hFFFF_FFFF;
                2: rb = ra;
                default: ;
            endcase
            rc = 1'($urandom);
            rs = 1'($urandom);
            txn("rand", ra, rb, rc, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
